// File: rtl/instruction_queue_if.sv
// Fetch-side and dispatch-side signal bundle of the instruction queue.
// Ports: slave = the queue (drives PC and the head/status outputs),
//        master = the memory/dispatch side (drives fetch, pop and flush controls).
interface instruction_queue_if #(
   parameter int ADDR_W = 2,
   parameter int PC_W   = 7
);
   logic              Fetch_Enable;
   logic [15:0]       Instr_Mem_Data;
   logic [PC_W-1:0]   PC;
   logic              Pop;
   logic              Flush;
   logic [PC_W-1:0]   Flush_PC;
   logic [15:0]       Instrucao_Despachada;
   logic              Empty;
   logic              Full;
   logic [ADDR_W:0]   Count;
   logic              Halted;

   modport slave (
      input  Fetch_Enable, Instr_Mem_Data, Pop, Flush, Flush_PC,
      output PC, Instrucao_Despachada, Empty, Full, Count, Halted
   );

   modport master (
      output Fetch_Enable, Instr_Mem_Data, Pop, Flush, Flush_PC,
      input  PC, Instrucao_Despachada, Empty, Full, Count, Halted
   );
endinterface

// File: rtl/instruction_queue.sv
// Purpose: fetch/buffer stage feeding dispatch; circular FIFO of 16-bit instructions.
// Latency: a word fetched at edge n is visible on Instrucao_Despachada right after edge n.
// Backpressure: Pop=0 holds the head; fetch stalls when full unless a pop frees a slot that cycle.
//
// Ports: Clock, Reset (async, active-high) plus iq (instruction_queue_if.slave):
//   Fetch_Enable, Instr_Mem_Data -> fetch request and memory word at PC
//   PC                           <- next fetch address
//   Pop, Flush, Flush_PC         -> dispatch pop, queue flush and fetch redirect
//   Instrucao_Despachada, Empty, Full, Count, Halted <- head word and status
// Optional: define IQ_HALT_EN to stop fetching on opcode [15:13]==3'b111.
module instruction_queue #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2,
   parameter int PC_W   = 7
) (
   input logic               Clock,
   input logic               Reset,
   instruction_queue_if.slave iq
);

   localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

   logic [15:0]       mem [DEPTH];
   logic [ADDR_W-1:0] head;
   logic [ADDR_W-1:0] tail;
   logic [ADDR_W:0]   count;
   logic [PC_W-1:0]   pc;
   logic              halted;

   logic empty;
   logic full;
   logic is_halt;
   logic fetch_ok;
   logic pop_eff;
   logic push_eff;

   assign empty = (count == '0);
   assign full  = (count == DEPTH_CNT);

`ifdef IQ_HALT_EN
   assign is_halt = (iq.Instr_Mem_Data[15:13] == 3'b111);
`else
   assign is_halt = 1'b0;
`endif

   // Flush wins over everything: no push or pop happens in the flush cycle.
   // A full queue may still accept a word when the head leaves in the same cycle.
   assign pop_eff  = iq.Pop & ~empty & ~iq.Flush;
   assign fetch_ok = iq.Fetch_Enable & ~halted & (~full | pop_eff) & ~iq.Flush;
   assign push_eff = fetch_ok & ~is_halt;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         pc    <= '0;
      end else if (iq.Flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         pc    <= iq.Flush_PC;
      end else begin
         if (push_eff) begin
            tail <= tail + 1'b1;
            pc   <= pc + 1'b1;
         end
         if (pop_eff) begin
            head <= head + 1'b1;
         end
         case ({push_eff, pop_eff})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

`ifdef IQ_HALT_EN
   // A HALT word is consumed by the fetch but never enqueued; fetch stays
   // stopped until Reset or Flush while queued entries keep draining.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         halted <= 1'b0;
      end else if (iq.Flush) begin
         halted <= 1'b0;
      end else if (fetch_ok && is_halt) begin
         halted <= 1'b1;
      end
   end
`else
   assign halted = 1'b0;
`endif

   // Storage has no reset; validity is tracked entirely by head/count.
   always_ff @(posedge Clock) begin
      if (push_eff) begin
         mem[tail] <= iq.Instr_Mem_Data;
      end
   end

   assign iq.PC                   = pc;
   assign iq.Empty                = empty;
   assign iq.Full                 = full;
   assign iq.Count                = count;
   assign iq.Halted               = halted;
   assign iq.Instrucao_Despachada = empty ? 16'h0000 : mem[head];

endmodule

// File: tb/tb_instruction_queue.sv
// Directed bench for instruction_queue: fill, full push/pop, drain, flush,
// PC wrap, HALT handling and asynchronous mid-operation reset.
module tb_instruction_queue;

   logic Clock = 1'b0;
   logic Reset;
   logic [15:0] imem [128];

   int compared   = 0;
   int mismatched = 0;

   instruction_queue_if #(.ADDR_W(2), .PC_W(7)) iq ();

   instruction_queue #(.DEPTH(4), .ADDR_W(2), .PC_W(7)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .iq    (iq.slave)
   );

   always #5 Clock = ~Clock;

   // Asynchronous-read instruction memory.
   assign iq.Instr_Mem_Data = imem[iq.PC];

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      for (int i = 0; i < 128; i++) imem[i] = 16'h1000 | 16'(i);
      imem[0] = 16'h4400;
      imem[1] = 16'h4480;
      imem[2] = 16'h4900;
      imem[3] = 16'h0000;

      Reset = 1'b1;
      iq.Fetch_Enable = 1'b0;
      iq.Pop = 1'b0;
      iq.Flush = 1'b0;
      iq.Flush_PC = '0;
      #12;
      check("rst_count", iq.Count, 0);
      check("rst_empty", iq.Empty, 1);
      check("rst_full",  iq.Full, 0);
      check("rst_pc",    iq.PC, 0);
      check("rst_halted", iq.Halted, 0);
      check("rst_out",   iq.Instrucao_Despachada, 16'h0000);

      // Fill
      Reset = 1'b0;
      iq.Fetch_Enable = 1'b1;
      step();
      check("first_out",   iq.Instrucao_Despachada, 16'h4400);
      check("first_count", iq.Count, 1);
      step(); step(); step();
      check("fill_full",  iq.Full, 1);
      check("fill_count", iq.Count, 4);
      check("fill_pc",    iq.PC, 4);
      check("fill_out",   iq.Instrucao_Despachada, 16'h4400);
      step();
      check("hold_pc",    iq.PC, 4);
      check("hold_count", iq.Count, 4);

      // Simultaneous push/pop while full
      iq.Pop = 1'b1;
      step();
      check("pp_count", iq.Count, 4);
      check("pp_out",   iq.Instrucao_Despachada, 16'h4480);
      check("pp_pc",    iq.PC, 5);

      // Drain with fetch disabled
      iq.Fetch_Enable = 1'b0;
      step();
      check("drain3_count", iq.Count, 3);
      check("drain3_out",   iq.Instrucao_Despachada, 16'h4900);
      step();
      check("drain2_count", iq.Count, 2);
      step();
      check("drain1_count", iq.Count, 1);
      check("drain1_out",   iq.Instrucao_Despachada, 16'h1004);
      step();
      check("drain0_count", iq.Count, 0);
      check("drain0_empty", iq.Empty, 1);
      check("drain0_out",   iq.Instrucao_Despachada, 16'h0000);
      step(); step();
      check("under_count", iq.Count, 0);
      check("under_pc",    iq.PC, 5);

      // Flush beats a pending pop
      iq.Pop = 1'b0;
      iq.Fetch_Enable = 1'b1;
      step(); step(); step();
      check("preflush_count", iq.Count, 3);
      check("preflush_pc",    iq.PC, 8);
      iq.Flush = 1'b1;
      iq.Flush_PC = 7'd20;
      iq.Pop = 1'b1;
      step();
      check("flush_count", iq.Count, 0);
      check("flush_pc",    iq.PC, 20);
      check("flush_empty", iq.Empty, 1);
      iq.Flush = 1'b0;
      iq.Pop = 1'b0;
      step();
      check("postflush_out", iq.Instrucao_Despachada, 16'h1014);
      check("postflush_pc",  iq.PC, 21);

      // PC wrap
      iq.Fetch_Enable = 1'b0;
      iq.Flush = 1'b1;
      iq.Flush_PC = 7'd127;
      step();
      check("wrap_pre_pc", iq.PC, 127);
      iq.Flush = 1'b0;
      iq.Fetch_Enable = 1'b1;
      step();
      check("wrap_pc",  iq.PC, 0);
      check("wrap_out", iq.Instrucao_Despachada, 16'h107f);

      // HALT opcode
      imem[2] = 16'hE000;
      iq.Fetch_Enable = 1'b0;
      iq.Flush = 1'b1;
      iq.Flush_PC = 7'd0;
      step();
      iq.Flush = 1'b0;
      iq.Fetch_Enable = 1'b1;
      step(); step(); step();
`ifdef IQ_HALT_EN
      check("halt_flag",  iq.Halted, 1);
      check("halt_pc",    iq.PC, 2);
      check("halt_count", iq.Count, 2);
`else
      check("halt_flag",  iq.Halted, 0);
      check("halt_pc",    iq.PC, 3);
      check("halt_count", iq.Count, 3);
`endif
      iq.Fetch_Enable = 1'b0;
      iq.Pop = 1'b1;
      step(); step();
`ifdef IQ_HALT_EN
      check("halt_drain_out",   iq.Instrucao_Despachada, 16'h0000);
      check("halt_drain_count", iq.Count, 0);
`else
      check("halt_drain_out",   iq.Instrucao_Despachada, 16'hE000);
      check("halt_drain_count", iq.Count, 1);
`endif
      iq.Pop = 1'b0;
      iq.Flush = 1'b1;
      step();
      check("flush_unhalt", iq.Halted, 0);
      check("flush_unhalt_count", iq.Count, 0);
      iq.Flush = 1'b0;

      // Asynchronous reset mid-operation
      iq.Fetch_Enable = 1'b1;
      step(); step();
      check("premid_count", iq.Count, 2);
      iq.Fetch_Enable = 1'b0;
      #2;
      Reset = 1'b1;
      #1;
      check("arst_count", iq.Count, 0);
      check("arst_empty", iq.Empty, 1);
      check("arst_pc",    iq.PC, 0);
      check("arst_out",   iq.Instrucao_Despachada, 16'h0000);
      #3;
      Reset = 1'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
